// File: rtl/decode_stage_pipe_pkg.sv
// Shared encodings and instruction field positions for the MIPS decode stage.
package decode_stage_pipe_pkg;

    typedef enum logic [1:0] {
        EXT_ZERO = 2'd0,
        EXT_SIGN = 2'd1,
        EXT_LUI  = 2'd2,
        EXT_NONE = 2'd3
    } ext_op_e;

    typedef enum logic [1:0] {
        A3_RT   = 2'd0,
        A3_RD   = 2'd1,
        A3_RA   = 2'd2,
        A3_ZERO = 2'd3
    } a3_sel_e;

    localparam logic [4:0] REG_RA = 5'd31;

    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 16;

endpackage

// File: rtl/decode_stage_pipe_rf_bypass.sv
// Register file with two combinational read ports and optional write-through
// bypass from the W-stage write port; register 0 is hard-wired to zero.
module decode_stage_pipe_rf_bypass
    import decode_stage_pipe_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int BYPASS_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] raddr,
        input logic              wr_en,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [DATA_W-1:0] wr_data,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] val;
        if (raddr == {ADDR_W{1'b0}}) begin
            val = {DATA_W{1'b0}};
        end else if ((BYPASS_EN != 0) && wr_en && (wr_addr == raddr)) begin
            val = wr_data;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Storage update; entry 0 is never written so it stays at its reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we && (waddr != {ADDR_W{1'b0}})) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read ports with write-through bypass.
    always_comb begin
        rdata1 = read_port(raddr1, we, waddr, wdata, mem_r[raddr1]);
        rdata2 = read_port(raddr2, we, waddr, wdata, mem_r[raddr2]);
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// MIPS decode stage: operand fetch/forwarding, immediate extension, destination
// selection and the D/E pipeline register with a saturating bubble counter.
module decode_stage_pipe
    import decode_stage_pipe_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int BYPASS_EN = 1,
    parameter int CNT_W     = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              in_valid,
    input  logic              stall_e,
    input  logic              flush_d,
    input  logic [31:0]       Instr_D,
    input  logic [31:0]       PC_D,
    input  logic [1:0]        ext_op,
    input  logic [1:0]        a3_sel,
    input  logic              fwd1_en,
    input  logic              fwd2_en,
    input  logic [DATA_W-1:0] FWD_D1,
    input  logic [DATA_W-1:0] FWD_D2,
    input  logic              RFWr,
    input  logic [ADDR_W-1:0] A3W,
    input  logic [DATA_W-1:0] WData,
    output logic [ADDR_W-1:0] D_rs_addr,
    output logic [ADDR_W-1:0] D_rt_addr,
    output logic [DATA_W-1:0] rd1_d,
    output logic [DATA_W-1:0] rd2_d,
    output logic              branch_eq,
    output logic              e_valid,
    output logic [31:0]       e_instr,
    output logic [31:0]       e_pc,
    output logic [DATA_W-1:0] e_rd1,
    output logic [DATA_W-1:0] e_rd2,
    output logic [DATA_W-1:0] e_ext,
    output logic [ADDR_W-1:0] e_a3,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [ADDR_W-1:0] rs_s;
    logic [ADDR_W-1:0] rt_s;
    logic [ADDR_W-1:0] rd_s;
    logic [IMM_W-1:0]  imm_s;
    logic [31:0]       lui_s;
    logic [DATA_W-1:0] rf_rd1_s;
    logic [DATA_W-1:0] rf_rd2_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;
    logic [DATA_W-1:0] ext_s;
    logic [ADDR_W-1:0] a3_s;

    logic              e_valid_r;
    logic [31:0]       e_instr_r;
    logic [31:0]       e_pc_r;
    logic [DATA_W-1:0] e_rd1_r;
    logic [DATA_W-1:0] e_rd2_r;
    logic [DATA_W-1:0] e_ext_r;
    logic [ADDR_W-1:0] e_a3_r;
    logic [CNT_W-1:0]  bubble_cnt_r;

    assign rs_s  = Instr_D[RS_LSB +: ADDR_W];
    assign rt_s  = Instr_D[RT_LSB +: ADDR_W];
    assign rd_s  = Instr_D[RD_LSB +: ADDR_W];
    assign imm_s = Instr_D[IMM_LSB +: IMM_W];
    assign lui_s = {imm_s, 16'h0000};

    decode_stage_pipe_rf_bypass #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_rf (
        .clk    (Clk),
        .rst    (Reset),
        .we     (RFWr),
        .waddr  (A3W),
        .wdata  (WData),
        .raddr1 (rs_s),
        .raddr2 (rt_s),
        .rdata1 (rf_rd1_s),
        .rdata2 (rf_rd2_s)
    );

    // Forwarded values take precedence over the register file (and its bypass).
    always_comb begin
        rd1_s = rf_rd1_s;
        rd2_s = rf_rd2_s;
        if (fwd1_en) begin
            rd1_s = FWD_D1;
        end else begin
            rd1_s = rf_rd1_s;
        end
        if (fwd2_en) begin
            rd2_s = FWD_D2;
        end else begin
            rd2_s = rf_rd2_s;
        end
    end

    // Immediate extension; the upper-immediate form is zero above bit 31.
    always_comb begin
        ext_s = {DATA_W{1'b0}};
        case (ext_op_e'(ext_op))
            EXT_ZERO: ext_s = DATA_W'(imm_s);
            EXT_SIGN: ext_s = {{(DATA_W-IMM_W){imm_s[IMM_W-1]}}, imm_s};
            EXT_LUI:  ext_s = DATA_W'(lui_s);
            EXT_NONE: ext_s = {DATA_W{1'b0}};
            default:  ext_s = {DATA_W{1'b0}};
        endcase
    end

    // Destination register; the link register truncates to all-ones.
    always_comb begin
        a3_s = {ADDR_W{1'b0}};
        case (a3_sel_e'(a3_sel))
            A3_RT:   a3_s = rt_s;
            A3_RD:   a3_s = rd_s;
            A3_RA:   a3_s = ADDR_W'(REG_RA);
            A3_ZERO: a3_s = {ADDR_W{1'b0}};
            default: a3_s = {ADDR_W{1'b0}};
        endcase
    end

    // D/E register: stall holds, flush or empty slot loads a bubble, else load.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            e_valid_r    <= 1'b0;
            e_instr_r    <= 32'h0000_0000;
            e_pc_r       <= 32'h0000_0000;
            e_rd1_r      <= {DATA_W{1'b0}};
            e_rd2_r      <= {DATA_W{1'b0}};
            e_ext_r      <= {DATA_W{1'b0}};
            e_a3_r       <= {ADDR_W{1'b0}};
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else if (!stall_e) begin
            if (flush_d || !in_valid) begin
                e_valid_r <= 1'b0;
                e_instr_r <= 32'h0000_0000;
                e_pc_r    <= 32'h0000_0000;
                e_rd1_r   <= {DATA_W{1'b0}};
                e_rd2_r   <= {DATA_W{1'b0}};
                e_ext_r   <= {DATA_W{1'b0}};
                e_a3_r    <= {ADDR_W{1'b0}};
                if (bubble_cnt_r != {CNT_W{1'b1}}) begin
                    bubble_cnt_r <= bubble_cnt_r + CNT_W'(1);
                end
            end else begin
                e_valid_r <= 1'b1;
                e_instr_r <= Instr_D;
                e_pc_r    <= PC_D;
                e_rd1_r   <= rd1_s;
                e_rd2_r   <= rd2_s;
                e_ext_r   <= ext_s;
                e_a3_r    <= a3_s;
            end
        end
    end

    assign D_rs_addr  = rs_s;
    assign D_rt_addr  = rt_s;
    assign rd1_d      = rd1_s;
    assign rd2_d      = rd2_s;
    assign branch_eq  = (rd1_s == rd2_s);
    assign e_valid    = e_valid_r;
    assign e_instr    = e_instr_r;
    assign e_pc       = e_pc_r;
    assign e_rd1      = e_rd1_r;
    assign e_rd2      = e_rd2_r;
    assign e_ext      = e_ext_r;
    assign e_a3       = e_a3_r;
    assign bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: one instance with bypass and a 16-bit counter,
// one without bypass and a 2-bit counter, both driven by the same stimulus.
module tb_decode_stage_pipe;

    logic        Clk, Reset, in_valid, stall_e, flush_d;
    logic [31:0] Instr_D, PC_D;
    logic [1:0]  ext_op, a3_sel;
    logic        fwd1_en, fwd2_en;
    logic [31:0] FWD_D1, FWD_D2;
    logic        RFWr;
    logic [4:0]  A3W;
    logic [31:0] WData;

    logic [4:0]  d0_rs, d0_rt, d0_a3, d1_rs, d1_rt, d1_a3;
    logic [31:0] d0_rd1, d0_rd2, d0_ei, d0_ep, d0_er1, d0_er2, d0_ee;
    logic [31:0] d1_rd1, d1_rd2, d1_ei, d1_ep, d1_er1, d1_er2, d1_ee;
    logic        d0_beq, d0_ev, d1_beq, d1_ev;
    logic [15:0] d0_cnt;
    logic [1:0]  d1_cnt;

    int checks;
    int failures;

    // Reference state: register contents and the expected D/E contents per instance.
    logic [31:0] model_rf [32];
    logic        ev_m  [2];
    logic [31:0] ei_m  [2];
    logic [31:0] ep_m  [2];
    logic [31:0] er1_m [2];
    logic [31:0] er2_m [2];
    logic [31:0] ee_m  [2];
    logic [4:0]  ea3_m [2];
    int unsigned cnt_m [2];

    decode_stage_pipe dut0 (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .stall_e(stall_e), .flush_d(flush_d),
        .Instr_D(Instr_D), .PC_D(PC_D), .ext_op(ext_op), .a3_sel(a3_sel),
        .fwd1_en(fwd1_en), .fwd2_en(fwd2_en), .FWD_D1(FWD_D1), .FWD_D2(FWD_D2),
        .RFWr(RFWr), .A3W(A3W), .WData(WData),
        .D_rs_addr(d0_rs), .D_rt_addr(d0_rt), .rd1_d(d0_rd1), .rd2_d(d0_rd2),
        .branch_eq(d0_beq), .e_valid(d0_ev), .e_instr(d0_ei), .e_pc(d0_ep),
        .e_rd1(d0_er1), .e_rd2(d0_er2), .e_ext(d0_ee), .e_a3(d0_a3), .bubble_cnt(d0_cnt)
    );

    decode_stage_pipe #(.BYPASS_EN(0), .CNT_W(2)) dut1 (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .stall_e(stall_e), .flush_d(flush_d),
        .Instr_D(Instr_D), .PC_D(PC_D), .ext_op(ext_op), .a3_sel(a3_sel),
        .fwd1_en(fwd1_en), .fwd2_en(fwd2_en), .FWD_D1(FWD_D1), .FWD_D2(FWD_D2),
        .RFWr(RFWr), .A3W(A3W), .WData(WData),
        .D_rs_addr(d1_rs), .D_rt_addr(d1_rt), .rd1_d(d1_rd1), .rd2_d(d1_rd2),
        .branch_eq(d1_beq), .e_valid(d1_ev), .e_instr(d1_ei), .e_pc(d1_ep),
        .e_rd1(d1_er1), .e_rd2(d1_er2), .e_ext(d1_ee), .e_a3(d1_a3), .bubble_cnt(d1_cnt)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%h expected=%h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Operand per the rules: forward wins, r0 is zero, bypass only on instance 0.
    function automatic logic [31:0] model_opnd(input int k, input logic fwd,
                                               input logic [31:0] fwdv, input logic [4:0] addr);
        if (fwd) return fwdv;
        if (addr == 5'd0) return 32'd0;
        if (k == 0 && RFWr && A3W == addr) return WData;
        return model_rf[addr];
    endfunction

    function automatic logic [31:0] model_ext(input logic [1:0] op, input logic [31:0] ins);
        int unsigned imm;
        imm = ins % 65536;
        case (op)
            2'd0: return imm;
            2'd1: return (imm >= 32768) ? imm + 32'hFFFF0000 : imm;
            2'd2: return imm * 65536;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [4:0] model_a3(input logic [1:0] sel, input logic [31:0] ins);
        case (sel)
            2'd0: return 5'((ins >> 16) % 32);
            2'd1: return 5'((ins >> 11) % 32);
            2'd2: return 5'd31;
            default: return 5'd0;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        for (int k = 0; k < 2; k++) begin
            ev_m[k] = 1'b0; ei_m[k] = 32'd0; ep_m[k] = 32'd0; er1_m[k] = 32'd0;
            er2_m[k] = 32'd0; ee_m[k] = 32'd0; ea3_m[k] = 5'd0; cnt_m[k] = 0;
        end
    endtask

    task automatic model_update();
        int unsigned max_cnt;
        for (int k = 0; k < 2; k++) begin
            max_cnt = (k == 0) ? 65535 : 3;
            if (!stall_e) begin
                if (flush_d || !in_valid) begin
                    ev_m[k] = 1'b0; ei_m[k] = 32'd0; ep_m[k] = 32'd0; er1_m[k] = 32'd0;
                    er2_m[k] = 32'd0; ee_m[k] = 32'd0; ea3_m[k] = 5'd0;
                    if (cnt_m[k] < max_cnt) cnt_m[k]++;
                end else begin
                    ev_m[k]  = 1'b1;
                    ei_m[k]  = Instr_D;
                    ep_m[k]  = PC_D;
                    er1_m[k] = model_opnd(k, fwd1_en, FWD_D1, Instr_D[25:21]);
                    er2_m[k] = model_opnd(k, fwd2_en, FWD_D2, Instr_D[20:16]);
                    ee_m[k]  = model_ext(ext_op, Instr_D);
                    ea3_m[k] = model_a3(a3_sel, Instr_D);
                end
            end
        end
        if (RFWr && A3W != 5'd0) model_rf[A3W] = WData;
    endtask

    task automatic check_dut(input int k, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [31:0] rd1, input logic [31:0] rd2, input logic beq,
                             input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                             input logic [31:0] er1, input logic [31:0] er2, input logic [31:0] ee,
                             input logic [4:0] a3, input logic [31:0] cnt);
        logic [31:0] x1, x2;
        x1 = model_opnd(k, fwd1_en, FWD_D1, Instr_D[25:21]);
        x2 = model_opnd(k, fwd2_en, FWD_D2, Instr_D[20:16]);
        chk("D_rs_addr", k, 32'(rs), 32'((Instr_D >> 21) % 32));
        chk("D_rt_addr", k, 32'(rt), 32'((Instr_D >> 16) % 32));
        chk("rd1_d", k, rd1, x1);
        chk("rd2_d", k, rd2, x2);
        chk("branch_eq", k, 32'(beq), (x1 == x2) ? 32'd1 : 32'd0);
        chk("e_valid", k, 32'(ev), 32'(ev_m[k]));
        chk("e_instr", k, ei, ei_m[k]);
        chk("e_pc", k, ep, ep_m[k]);
        chk("e_rd1", k, er1, er1_m[k]);
        chk("e_rd2", k, er2, er2_m[k]);
        chk("e_ext", k, ee, ee_m[k]);
        chk("e_a3", k, 32'(a3), 32'(ea3_m[k]));
        chk("bubble_cnt", k, cnt, cnt_m[k]);
    endtask

    task automatic check_all();
        check_dut(0, d0_rs, d0_rt, d0_rd1, d0_rd2, d0_beq, d0_ev, d0_ei, d0_ep,
                  d0_er1, d0_er2, d0_ee, d0_a3, 32'(d0_cnt));
        check_dut(1, d1_rs, d1_rt, d1_rd1, d1_rd2, d1_beq, d1_ev, d1_ei, d1_ep,
                  d1_er1, d1_er2, d1_ee, d1_a3, 32'(d1_cnt));
    endtask

    task automatic settle_check();
        #2;
        check_all();
    endtask

    task automatic tick();
        @(posedge Clk);
        if (Reset) model_clear();
        else model_update();
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 1'b0; stall_e = 1'b0; flush_d = 1'b0; Instr_D = 32'd0; PC_D = 32'd0;
        ext_op = 2'd0; a3_sel = 2'd0; fwd1_en = 1'b0; fwd2_en = 1'b0; FWD_D1 = 32'd0;
        FWD_D2 = 32'd0; RFWr = 1'b0; A3W = 5'd0; WData = 32'd0;
    endtask

    task automatic randomize_inputs();
        in_valid = ($urandom_range(0, 9) < 8);
        stall_e  = ($urandom_range(0, 3) == 0);
        flush_d  = ($urandom_range(0, 6) == 0);
        Instr_D  = $urandom;
        if ($urandom_range(0, 4) == 0) Instr_D[20:16] = Instr_D[25:21];
        PC_D     = $urandom;
        ext_op   = 2'($urandom_range(0, 3));
        a3_sel   = 2'($urandom_range(0, 3));
        fwd1_en  = ($urandom_range(0, 3) == 0);
        fwd2_en  = ($urandom_range(0, 3) == 0);
        FWD_D1   = $urandom;
        FWD_D2   = $urandom;
        RFWr     = ($urandom_range(0, 1) == 1);
        A3W      = ($urandom_range(0, 2) == 0) ? Instr_D[25:21] : 5'($urandom_range(0, 31));
        WData    = $urandom;
    endtask

    localparam logic [31:0] INSTR_A = 32'h0123_4567;
    localparam logic [31:0] PC_A    = 32'h0040_0010;

    initial begin
        checks = 0;
        failures = 0;
        Reset = 1'b1;
        clear_inputs();
        model_clear();

        settle_check();
        chk("rst_e_valid", 0, 32'(d0_ev), 32'd0);
        chk("rst_bubble", 0, 32'(d0_cnt), 32'd0);
        tick();
        Reset = 1'b0;

        // Old value into r5, then a same-cycle write of a new value.
        RFWr = 1'b1; A3W = 5'd5; WData = 32'h1111_1111;
        settle_check();
        tick();
        Instr_D = 32'd5 << 21; in_valid = 1'b1; WData = 32'hDEAD_BEEF;
        settle_check();
        chk("bypass_on", 0, d0_rd1, 32'hDEAD_BEEF);
        chk("bypass_off", 1, d1_rd1, 32'h1111_1111);
        tick();

        // Writes to r0 are dropped; forwarding overrides.
        A3W = 5'd0; WData = 32'h0000_1234; Instr_D = 32'd0;
        settle_check();
        tick();
        RFWr = 1'b0;
        settle_check();
        chk("r0_read", 0, d0_rd1, 32'd0);
        chk("r0_read", 1, d1_rd1, 32'd0);
        fwd1_en = 1'b1; FWD_D1 = 32'd7;
        settle_check();
        chk("fwd_r0", 0, d0_rd1, 32'd7);
        chk("fwd_r0", 1, d1_rd1, 32'd7);
        fwd1_en = 1'b0;
        tick();

        // Immediate forms of 0x8001 and the link destination.
        Instr_D = 32'h2000_8001; ext_op = 2'd1; a3_sel = 2'd2;
        settle_check();
        tick();
        settle_check();
        chk("sext", 0, d0_ee, 32'hFFFF_8001);
        chk("a3_ra", 1, 32'(d1_a3), 32'd31);
        ext_op = 2'd0;
        tick();
        settle_check();
        chk("zext", 0, d0_ee, 32'h0000_8001);
        ext_op = 2'd2;
        tick();
        settle_check();
        chk("lui", 1, d1_ee, 32'h8001_0000);

        // Reset arriving mid-cycle during a stall.
        stall_e = 1'b1; Instr_D = $urandom;
        settle_check();
        tick();
        Instr_D = 32'd5 << 21; ext_op = 2'd0; a3_sel = 2'd0;
        #2;
        Reset = 1'b1;
        #1;
        model_clear();
        check_all();
        chk("rst_r5_read", 0, d0_rd1, 32'd0);
        chk("rst_e_instr", 0, d0_ei, 32'd0);
        tick();
        Reset = 1'b0;

        // Load A, then stall+flush for three cycles, then flush alone.
        stall_e = 1'b0; flush_d = 1'b0; in_valid = 1'b1; Instr_D = INSTR_A; PC_D = PC_A;
        settle_check();
        tick();
        stall_e = 1'b1; flush_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Instr_D = $urandom; PC_D = $urandom;
            settle_check();
            tick();
        end
        settle_check();
        chk("stall_instr", 0, d0_ei, INSTR_A);
        chk("stall_pc", 1, d1_ep, PC_A);
        chk("stall_bubble", 0, 32'(d0_cnt), 32'd0);
        stall_e = 1'b0;
        tick();
        settle_check();
        chk("flush_valid", 0, 32'(d0_ev), 32'd0);
        chk("flush_bubble", 0, 32'(d0_cnt), 32'd1);
        chk("flush_bubble", 1, 32'(d1_cnt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            settle_check();
        end
        chk("bubble_five", 0, 32'(d0_cnt), 32'd5);
        chk("bubble_sat", 1, 32'(d1_cnt), 32'd3);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            settle_check();
            tick();
        end
        settle_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised decode-stage datapath for the pipelined MIPS core.
- Contains a register file with configurable width and depth, and optional write-through bypass from the W-stage write port.
- Selects D-stage operands with hazard-unit forwarding, extends the immediate and chooses the destination register.
- Registers all of this into a D/E pipeline register that supports stall, flush and bubble insertion, plus a saturating bubble counter for performance monitoring.

Parameters:
- DATA_W, 32: register/data width; must be ≥32.
- ADDR_W, 5: register address width; register count is 2**ADDR_W.
- BYPASS_EN, 1: 1 = a same-cycle W-stage write is visible on D-stage reads.
- CNT_W, 16: width of the bubble counter.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous reset, active-high.
- in_valid  in  1  Instr_D/PC_D hold a real instruction.
- stall_e  in  1  hold the D/E register (E stage cannot accept).
- flush_d  in  1  replace the D/E load with a bubble.
- Instr_D  in  32  D-stage instruction.
- PC_D  in  32  D-stage PC.
- ext_op  in  2  0 zero-extend, 1 sign-extend, 2 imm<<16, 3 constant zero.
- a3_sel  in  2  0 rt, 1 rd, 2 register 31, 3 register 0.
- fwd1_en, fwd2_en  in  1 each  use forwarded value for rs / rt.
- FWD_D1, FWD_D2  in  DATA_W each  forwarded rs / rt values.
- RFWr  in  1  W-stage write enable.
- A3W  in  ADDR_W  W-stage write address.
- WData  in  DATA_W  W-stage write data.
- D_rs_addr, D_rt_addr  out  ADDR_W each  Instr_D[25:21] / [20:16], low ADDR_W bits.
- rd1_d, rd2_d  out  DATA_W each  final D-stage operands (combinational).
- branch_eq  out  1  rd1_d == rd2_d (combinational).
- e_valid  out  1  D/E holds a real instruction.
- e_instr, e_pc  out  32 each  registered instruction / PC.
- e_rd1, e_rd2, e_ext  out  DATA_W each  registered operands and extended immediate.
- e_a3  out  ADDR_W  registered destination register.
- bubble_cnt  out  CNT_W  count of inserted bubbles.

Behaviour:
- Reset (asynchronous): all registers, e_* outputs and bubble_cnt go to 0.
- Register file write: on a Clk rising edge with RFWr=1 and A3W≠0, write WData to register A3W. Writes to register 0 are ignored; register 0 always reads 0.
- Register file read (combinational), evaluated per port:
  - If the address is 0, the result is 0.
  - Otherwise, if BYPASS_EN=1 and RFWr=1 and A3W equals the address, the result is WData.
  - Otherwise, the result is the stored value.
- Operand selection: if fwdN_en=1, rdN_d = FWD_DN; otherwise rdN_d is the register file read. Forwarding overrides bypass.
- Immediate extension:
  - Sign extension replicates bit 15 up to DATA_W.
  - imm<<16 zero-fills the low 16 bits and all bits above bit 31.
- Destination register (A3) calculation:
  - Register 31 is all-ones truncated to ADDR_W.
  - If ADDR_W<5, rt/rd are truncated to ADDR_W bits.
- D/E register update at each rising edge, in priority order:
  1. stall_e=1: hold everything (stall takes priority over flush_d); bubble_cnt holds.
  2. Otherwise, if flush_d=1 or in_valid=0: load a bubble. e_valid=0 and all other e_* fields are 0. bubble_cnt increments and saturates at all-ones.
  3. Otherwise: e_valid=1; e_instr=Instr_D, e_pc=PC_D, e_rd1=rd1_d, e_rd2=rd2_d, e_ext = extended immediate, e_a3 = selected destination.
- Latency: one cycle from D inputs to e_* outputs; zero cycles to rd1_d, rd2_d and branch_eq.
- Reset asserted mid-stall clears state immediately. After Reset deasserts, the first edge follows the normal priority order.

Decomposition:
- Shared package holds the ext_op and a3_sel encodings, the REG_RA constant (31), and the instruction field bit positions.
- One natural sub-module, rf_bypass: the register file with the read ports and bypass logic.
- Selection, extension, the D/E register and the counter stay in the top level.

Test Plan:
- Reset: assert Reset mid-cycle → all e_* = 0, bubble_cnt = 0, reads of register 5 return 0.
- Bypass: RFWr=1, A3W=5, WData=0xDEADBEEF, Instr_D rs=5 → rd1_d = 0xDEADBEEF in the same cycle with BYPASS_EN=1, and the old value with BYPASS_EN=0.
- Register 0: write 0x1234 to register 0, then read rs=0 → 0. fwd1_en=1 with FWD_D1=7 → rd1_d = 7.
- Extension and destination: imm 0x8001 → sign-extended 0xFFFF8001, zero-extended 0x00008001, imm<<16 0x80010000. a3_sel=2 → e_a3 = 31.
- Stall, then simultaneous stall and flush: load instruction A, then stall_e=1 with flush_d=1 for 3 cycles → e_* stays A and bubble_cnt is unchanged. Then flush_d=1 alone → e_valid=0, bubble_cnt = 1.
- Saturation: CNT_W=2, apply 5 consecutive bubbles → bubble_cnt = 3.
